reaction_session_ctrl: RTL and testbench
========================================

# reaction_session_ctrl

Session controller for the reaction-timer datapath. It runs a multi-round reaction test: it arms a random pre-stimulus delay, lights the stimulus LED, and measures the response in milliseconds. It detects early presses and timeouts, and accumulates best and average results across rounds. It sits between the debounced button pulses and LFSR random source on one side and the seven-segment formatter on the other; all outputs are binary milliseconds, and BCD conversion happens downstream.

## Interface
- CLK_HZ, 100_000_000: clock frequency.
- TICK_DIV, CLK_HZ/1000: clocks per millisecond tick (reduced for simulation).
- ROUNDS, 4: rounds per session; power of two, 2..8.
- GAP_MS, 1000: inter-round pause in ms.

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start_btn  in  1  one-cycle pulse, debounced upstream
- stop_btn  in  1  one-cycle pulse, debounced upstream
- clear_btn  in  1  one-cycle pulse, debounced upstream
- rand_val  in  4  random value, sampled in ARM
- led0  out  1  stimulus LED
- busy  out  1  session in progress (ARM..GAP)
- round_idx  out  3  current round, 0-based
- last_ms  out  14  most recent round result
- best_ms  out  14  minimum result this session
- avg_ms  out  14  session average, valid when done
- done  out  1  session complete
- early_err  out  1  early press detected

## Operation
- States:
  - IDLE
  - ARM
  - WAIT
  - REACT
  - RECORD
  - GAP
  - DONE
  - ERR
- Outputs are Moore/registered:
  - led0 = (state==REACT)
  - done = (state==DONE)
  - early_err = (state==ERR)
  - busy = state in {ARM, WAIT, REACT, RECORD, GAP}
- Reset (any state, asynchronous): state IDLE, every output and counter 0, best_ms = 9999.
- clear_btn has highest priority in every state. Next state is IDLE, and it clears round_idx, last_ms, avg_ms, the accumulator, and sets best_ms = 9999.
- IDLE/DONE/ERR + start_btn -> ARM. This clears round_idx, accumulator, last_ms and avg_ms, and sets best_ms = 9999. start_btn in any other state is ignored.
- ARM (1 cycle): delay_cnt <= (rand_val + 2) * 250, giving 500..4250 ms. Next state WAIT; the ms prescaler clears.
- WAIT:
  - Decrement delay_cnt on each ms tick.
  - When delay_cnt == 0 -> REACT; react_cnt and prescaler clear.
  - stop_btn in WAIT -> ERR (early press). This takes priority over reaching zero in the same cycle.
- REACT:
  - react_cnt increments on each ms tick and saturates at 9999.
  - stop_btn -> RECORD, latching the current react_cnt; a tick in the same cycle is not applied.
  - react_cnt reaching 9999 -> RECORD with value 9999 (timeout).
- RECORD (1 cycle):
  - last_ms <= value.
  - best_ms <= min(best_ms, value).
  - acc <= acc + value; acc is 17 bits, no overflow possible.
  - If round_idx == ROUNDS-1 -> DONE, with avg_ms <= acc_final >> log2(ROUNDS) (truncating).
  - Otherwise round_idx++ and -> GAP.
- GAP: count GAP_MS ticks, then -> ARM. stop_btn is ignored.
- DONE/ERR: hold all results until start_btn or clear_btn.

## Timing
- The ms tick is a one-cycle pulse every TICK_DIV clocks from a prescaler. The prescaler clears on entry to WAIT, REACT and GAP, so the first tick in those states comes TICK_DIV clocks after entry.
- start_btn at cycle n -> ARM at n+1, WAIT at n+2.
- WAIT lasts delay_ms*TICK_DIV cycles. led0 rises on the cycle REACT is entered.
- stop_btn at cycle n in REACT:
  - RECORD and led0 = 0 at n+1.
  - last_ms and best_ms are valid at n+2.
  - done and avg_ms are valid at n+2 on the final round.
- Reported reaction = floor(elapsed clocks / TICK_DIV), saturating at 9999.
- Reset mid-session: immediate IDLE; no partial result is retained.

## Test plan
- Reset values: assert rst mid-REACT -> led0 = 0, busy = 0, state IDLE, best_ms = 9999, all other outputs 0.
- Single round, TICK_DIV = 10, ROUNDS = 2, rand_val = 0:
  - start_btn -> led0 rises 5000 clocks after WAIT entry.
  - stop_btn 1234 clocks after led0 rises -> last_ms = 123.
- Full session, ROUNDS = 4, with stops at 200, 150, 300 and 250 ms -> best_ms = 150, avg_ms = 225, done = 1, round_idx = 3.
- Early press: stop_btn during WAIT -> early_err = 1, led0 never rises. Then start_btn -> fresh session, early_err = 0.
- Timeout: no stop_btn -> last_ms = 9999 after 9999 ticks of REACT. Then stop_btn arriving together with the saturating tick -> recorded 9999 once.
- Priority: clear_btn and stop_btn in the same REACT cycle -> IDLE, last_ms = 0, best_ms = 9999. start_btn during GAP is ignored.

Source files
------------

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction-timer session controller: random pre-stimulus delay, ms-resolution
// response measurement, early-press/timeout detection, best and average tracking.
`timescale 1ns/1ps
module reaction_session_ctrl #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_DIV = CLK_HZ / 1000,
    parameter int ROUNDS   = 4,
    parameter int GAP_MS   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic        clear_btn,
    input  logic [3:0]  rand_val,
    output logic        led0,
    output logic        busy,
    output logic [2:0]  round_idx,
    output logic [13:0] last_ms,
    output logic [13:0] best_ms,
    output logic [13:0] avg_ms,
    output logic        done,
    output logic        early_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_REACT  = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int          PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          LOG2R  = $clog2(ROUNDS);
    localparam logic [13:0] MAX_MS = 14'd9999;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   cnt_q, cnt_d;      // WAIT delay and GAP pause share this down-counter
    logic [13:0]   react_q, react_d;
    logic [2:0]    round_q, round_d;
    logic [13:0]   last_q, last_d;
    logic [13:0]   best_q, best_d;
    logic [13:0]   avg_q, avg_d;
    logic [16:0]   acc_q, acc_d;

    logic        tick;
    logic        clear_results;
    logic        timing_state;
    logic [16:0] acc_sum;

    assign tick         = (presc_q == PW'(TICK_DIV - 1));
    assign timing_state = (state_q == S_WAIT) || (state_q == S_REACT) || (state_q == S_GAP);
    assign acc_sum      = acc_q + {3'b000, react_q};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        react_d       = react_q;
        round_d       = round_q;
        last_d        = last_q;
        best_d        = best_q;
        avg_d         = avg_q;
        acc_d         = acc_q;
        clear_results = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_btn) begin
                    state_d       = S_ARM;
                    clear_results = 1'b1;
                end
            end
            S_ARM: begin
                cnt_d   = (14'(rand_val) + 14'd2) * 14'd250;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_btn) begin
                    state_d = S_ERR;
                end else if (tick) begin
                    cnt_d = cnt_q - 14'd1;
                    if (cnt_q <= 14'd1) begin
                        state_d = S_REACT;
                        react_d = '0;
                    end
                end
            end
            S_REACT: begin
                // A stop in the same cycle as a tick latches the un-incremented count
                if (stop_btn || (react_q == MAX_MS)) begin
                    state_d = S_RECORD;
                end else if (tick) begin
                    react_d = react_q + 14'd1;
                end
            end
            S_RECORD: begin
                last_d = react_q;
                if (react_q < best_q) begin
                    best_d = react_q;
                end
                acc_d = acc_sum;
                if (round_q == 3'(ROUNDS - 1)) begin
                    avg_d   = 14'(acc_sum >> LOG2R);
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 3'd1;
                    cnt_d   = 14'(GAP_MS);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    cnt_d = cnt_q - 14'd1;
                    if (cnt_q <= 14'd1) begin
                        state_d = S_ARM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_btn) begin
            state_d       = S_IDLE;
            clear_results = 1'b1;
        end

        if (clear_results) begin
            round_d = '0;
            last_d  = '0;
            avg_d   = '0;
            acc_d   = '0;
            best_d  = MAX_MS;
        end

        // Prescaler restarts on every state change so each timed state sees a full first tick
        if ((state_d != state_q) || !timing_state || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            react_q <= '0;
            round_q <= '0;
            last_q  <= '0;
            best_q  <= MAX_MS;
            avg_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            react_q <= react_d;
            round_q <= round_d;
            last_q  <= last_d;
            best_q  <= best_d;
            avg_q   <= avg_d;
            acc_q   <= acc_d;
        end
    end

    assign led0      = (state_q == S_REACT);
    assign done      = (state_q == S_DONE);
    assign early_err = (state_q == S_ERR);
    assign busy      = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_REACT) ||
                       (state_q == S_RECORD) || (state_q == S_GAP);
    assign round_idx = round_q;
    assign last_ms   = last_q;
    assign best_ms   = best_q;
    assign avg_ms    = avg_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Randomized session bench for reaction_session_ctrl; expectations come from a per-round
// model of reaction = floor(clocks/TICK_DIV) saturating at 9999, best = min, avg = sum/ROUNDS.
`timescale 1ns/1ps
module tb_reaction_session_ctrl;

    localparam int TD    = 2;
    localparam int NR    = 4;
    localparam int GAP   = 20;
    localparam int MAXMS = 9999;

    // round modes
    localparam int M_STOP    = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_CLEAR   = 2;
    localparam int M_EARLY   = 3;
    localparam int M_RESET   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn, stop_btn, clear_btn;
    logic [3:0]  rand_val;
    logic        led0, busy, done, early_err;
    logic [2:0]  round_idx;
    logic [13:0] last_ms, best_ms, avg_ms;

    reaction_session_ctrl #(
        .CLK_HZ  (TD * 1000),
        .TICK_DIV(TD),
        .ROUNDS  (NR),
        .GAP_MS  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_btn(start_btn),
        .stop_btn (stop_btn),
        .clear_btn(clear_btn),
        .rand_val (rand_val),
        .led0     (led0),
        .busy     (busy),
        .round_idx(round_idx),
        .last_ms  (last_ms),
        .best_ms  (best_ms),
        .avg_ms   (avg_ms),
        .done     (done),
        .early_err(early_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int exp_sum, exp_best, exp_last, exp_ridx;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_sum  = 0;
        exp_best = MAXMS;
        exp_last = 0;
        exp_ridx = 0;
    endtask

    task automatic check_idle_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_led"}, led0, 0);
        check({tag, "_round"}, round_idx, 0);
        check({tag, "_last"}, last_ms, 0);
        check({tag, "_best"}, best_ms, MAXMS);
        check({tag, "_avg"}, avg_ms, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, early_err, 0);
    endtask

    task automatic start_session();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        model_clear();
        check("start_busy", busy, 1);
        check("start_round", round_idx, 0);
        check("start_last", last_ms, 0);
        check("start_best", best_ms, MAXMS);
        check("start_avg", avg_ms, 0);
        check("start_err", early_err, 0);
        check("start_done", done, 0);
    endtask

    // Entered in the ARM cycle; t is clocks into REACT (or into WAIT for M_EARLY).
    task automatic do_round(input int mode, input int rv, input int t, input bit gap_start);
        int delay_clk, cnt, val;
        bit lit;
        rand_val  = 4'(rv);
        step();
        delay_clk = (rv + 2) * 250 * TD;

        if (mode == M_EARLY) begin
            lit = 1'b0;
            for (int i = 0; i < t; i++) begin
                step();
                if (led0) lit = 1'b1;
            end
            stop_btn = 1'b1;
            step();
            stop_btn = 1'b0;
            check("early_err", early_err, 1);
            check("early_busy", busy, 0);
            for (int i = 0; i < delay_clk; i++) begin
                if (led0) lit = 1'b1;
                step();
            end
            check("early_noled", int'(lit), 0);
            check("early_hold", early_err, 1);
            $display("[TB] round %0d early press rv=%0d at wait clock %0d", exp_ridx, rv, t);
            return;
        end

        cnt = 0;
        while (!led0 && cnt < delay_clk + 50) begin
            step();
            cnt++;
        end
        check("led_rise", cnt, delay_clk);

        case (mode)
            M_STOP: begin
                repeat (t) step();
                stop_btn = 1'b1;
                step();
                stop_btn = 1'b0;
                check("rec_led", led0, 0);
                step();
                val = (t / TD > MAXMS) ? MAXMS : t / TD;
            end
            M_TIMEOUT: begin
                cnt = 0;
                while (led0 && cnt < MAXMS * TD + 50) begin
                    step();
                    cnt++;
                end
                check("timeout_end", int'(led0), 0);
                step();
                val = MAXMS;
            end
            M_CLEAR: begin
                repeat (t) step();
                stop_btn  = 1'b1;
                clear_btn = 1'b1;
                step();
                stop_btn  = 1'b0;
                clear_btn = 1'b0;
                model_clear();
                check_idle_cleared("clear");
                $display("[TB] round clear+stop at react clock %0d", t);
                return;
            end
            default: begin
                repeat (t) step();
                #2 rst = 1'b1;
                #1;
                model_clear();
                check_idle_cleared("rst_async");
                @(posedge clk);
                #1 rst = 1'b0;
                step();
                check("rst_stay_idle", busy, 0);
                $display("[TB] reset mid-REACT at react clock %0d", t);
                return;
            end
        endcase

        exp_last = val;
        if (val < exp_best) exp_best = val;
        exp_sum += val;
        check("last_ms", last_ms, exp_last);
        check("best_ms", best_ms, exp_best);
        $display("[TB] round %0d mode %0d rv=%0d react_clk=%0d -> last=%0d best=%0d",
                 exp_ridx, mode, rv, t, last_ms, best_ms);

        if (exp_ridx == NR - 1) begin
            check("fin_done", done, 1);
            check("fin_avg", avg_ms, exp_sum / NR);
            check("fin_round", round_idx, NR - 1);
            check("fin_busy", busy, 0);
        end else begin
            exp_ridx++;
            check("gap_round", round_idx, exp_ridx);
            check("gap_busy", busy, 1);
            check("gap_done", done, 0);
            for (int j = 0; j < GAP * TD; j++) begin
                if (gap_start && j == 3) start_btn = 1'b1;
                step();
                start_btn = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        clear_btn = 1'b0;
        rand_val  = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        model_clear();
        check_idle_cleared("reset");

        // directed full session: 200, 150, 300, 250 ms
        start_session();
        do_round(M_STOP, 0, 200 * TD + 1, 1'b0);
        do_round(M_STOP, 0, 150 * TD, 1'b1);
        do_round(M_STOP, 0, 300 * TD + 1, 1'b0);
        do_round(M_STOP, 0, 250 * TD, 1'b0);
        check("dir_best", best_ms, 150);
        check("dir_avg", avg_ms, 225);
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        repeat (10) step();
        check("done_hold", done, 1);
        check("done_hold_avg", avg_ms, 225);

        // randomized session
        start_session();
        for (int r = 0; r < NR; r++) begin
            do_round(M_STOP, int'($urandom_range(0, 3)), int'($urandom_range(0, 400 * TD)), r == 1);
        end

        // clear and stop in the same REACT cycle
        start_session();
        do_round(M_STOP, int'($urandom_range(0, 3)), int'($urandom_range(50, 300)) * TD, 1'b0);
        do_round(M_CLEAR, 0, int'($urandom_range(10, 100)), 1'b0);

        // early presses: random point, then the cycle the delay would have expired
        start_session();
        do_round(M_EARLY, int'($urandom_range(0, 3)), int'($urandom_range(0, 500)), 1'b0);
        start_session();
        do_round(M_EARLY, 1, 3 * 250 * TD - 1, 1'b0);

        // fresh session after error, then reset mid-REACT
        start_session();
        do_round(M_STOP, 0, 100 * TD, 1'b0);
        do_round(M_RESET, 0, 50, 1'b0);

        // timeout, then stop coinciding with saturation
        start_session();
        do_round(M_TIMEOUT, 0, 0, 1'b0);
        do_round(M_STOP, 0, MAXMS * TD, 1'b0);
        check("sat_sum_best", best_ms, MAXMS);
        clear_btn = 1'b1;
        step();
        clear_btn = 1'b0;
        model_clear();
        check_idle_cleared("final_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
